batcharger_ctrl_fsm: RTL and testbench
======================================

Name: batcharger_ctrl_fsm

Overview:
Digital charge controller that sits directly upstream of the 64b real-coded battery-charger power stage. It drives that stage's cc/tc/cv/en mode controls and its icc/itc/vcv codes. It consumes 8-bit ADC samples of battery voltage (51 codes/V) and battery current (255 = 1C), and sequences trickle → constant-current → constant-voltage → done. It applies debounce, charge timeouts and a temperature interlock.

Parameters:
DEB, 4, consecutive cycles an exit condition must hold before a state transition (1..15).
TW, 16, width of the total-charge and CV timers.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
en  in  1  charger enable; low forces IDLE.
tempok  in  1  battery temperature within limits.
vbat  in  8  battery voltage ADC code, unsigned.
ibat  in  8  battery current ADC code, unsigned.
vcutoff  in  8  TC→CC threshold (e.g. 153 = 3.0 V).
vpreset  in  8  recharge threshold (e.g. 178 = 3.5 V).
iend  in  8  CV termination current code.
tmax  in  TW  total charge timeout, cycles.
tcvmax  in  TW  CV-phase timeout, cycles.
icc_cfg, itc_cfg, vcv_cfg  in  8 each  requested CC current, TC current, CV target codes.
cc, tc, cv  out  1 each  power-stage mode enables, one-hot or all zero.
pwr_en  out  1  power-stage enable; high in TC/CC/CV.
icc, itc, vcv  out  8 each  latched codes to the power stage.
done  out  1  high in DONE.
fault  out  1  high in FAULT.
state  out  3  current state encoding, for debug.

Behaviour:
- Reset (synchronous): state = IDLE; cc, tc, cv, pwr_en, done, fault = 0; icc, itc, vcv = 0; timers and debounce counter = 0. A reset asserted mid-charge takes effect on the next rising edge.
- All outputs are Moore, decoded from the state register. They change in the cycle the state register changes; no combinational path runs from inputs to outputs.
- States and encoding: IDLE=0, TC=1, CC=2, CV=3, DONE=4, FAULT=5.
- Per-cycle priority: rst > en=0 (→IDLE, from any state) > total timeout (→FAULT) > tempok=0 (TC/CC/CV → IDLE) > normal transition.
- IDLE:
  - When en=1 and tempok=1, latch icc_cfg, itc_cfg and vcv_cfg into icc, itc and vcv.
  - Then go to TC if vbat < vcutoff, to CC if vcutoff ≤ vbat < vpreset, or to DONE if vbat ≥ vpreset.
  - The IDLE exit needs no debounce.
- TC: tc=1. Go to CC after vbat ≥ vcutoff holds for DEB consecutive cycles.
- CC: cc=1. Go to CV after vbat ≥ vcv (latched) holds for DEB cycles.
- CV: cv=1. Go to DONE after ibat ≤ iend holds for DEB cycles, or immediately when the CV timer reaches tcvmax.
- DONE: done=1, pwr_en=0. Go to CC after vbat < vpreset holds for DEB cycles (recharge). The latched codes are kept.
- FAULT: fault=1, all modes 0. Leave only via en=0 (→IDLE) or rst.
- Debounce counter:
  - Increments while the current state's exit condition is true.
  - Clears when the condition is false and on every state change.
  - The transition fires on the edge where the count would reach DEB. With DEB=4, the condition true in cycles n..n+3 gives the new state visible in cycle n+4.
- Total timer:
  - Counts every cycle in TC/CC/CV and saturates at all-ones.
  - Clears in IDLE and DONE.
  - Timer == tmax → FAULT on the next edge.
  - tmax=0 disables the timeout.
- CV timer: counts only in CV and clears on CV entry. tcvmax=0 disables it.
- All comparisons are unsigned 8-bit. Latched codes do not change outside IDLE.
- Simultaneous events:
  - Timeout and a CC→CV qualification on the same edge → FAULT wins.
  - tempok=0 and qualified exit on the same edge → IDLE wins.

Decomposition:
- batcharger_pkg holds:
  - the state enum and its 3-bit encoding;
  - default threshold constants: VCUTOFF_3V0=153, VPRESET_3V5=178, VCV_3V7=188, IEND_C20=13;
  - the DEB default.
- One sub-module, batcharger_sat_timer (TW-bit saturating counter with clr, inc and terminal-compare against a limit, where limit 0 means never). It is instantiated twice, for the total and CV timers.

Test Plan:
1. Full cycle, DEB=4, vcv_cfg=188, vcutoff=153, iend=13.
   - vbat=140 → TC with itc latched.
   - vbat=153 held 4 cycles → cc=1 in cycle 5.
   - vbat=188 held 4 cycles → cv=1.
   - ibat=13 held 4 cycles → done=1, all modes 0.
2. Glitch rejection: in TC at vbat=150, pulse vbat=160 for 3 cycles, then back to 150 → tc stays 1 and the debounce count clears.
3. Timeout: tmax=100, vbat stuck at 170 in CC → fault=1 exactly 100 cycles after leaving IDLE. fault holds until en=0, then IDLE the next cycle.
4. Interlock and reset: in CV, drop tempok → cv=0 and state=IDLE next cycle, timers cleared. Separately, assert rst mid-CC → all outputs 0 after one edge.
5. Recharge: in DONE, vbat=170 (< vpreset=178) held 4 cycles → cc=1 with the original icc. Change icc_cfg while in DONE → icc is unchanged.
6. Priority: tmax reached on the same edge that CC→CV qualifies → FAULT, not CV. Also, en low while in FAULT → IDLE.

Source files
------------

// File: rtl/batcharger_pkg.sv
// Shared definitions for the battery-charger control FSM.
// - state_t: 3-bit state encoding. It is also exported on the debug "state" port.
// - Default threshold codes for a single Li-ion cell. The scaling is 51 codes/V,
//   and 255 = 1C for current.
// - DEB_DEFAULT: default debounce length in cycles.
package batcharger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TC    = 3'd1,
        ST_CC    = 3'd2,
        ST_CV    = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [7:0] VCUTOFF_3V0 = 8'd153;
    localparam logic [7:0] VPRESET_3V5 = 8'd178;
    localparam logic [7:0] VCV_3V7     = 8'd188;
    localparam logic [7:0] IEND_C20    = 8'd13;

    localparam int DEB_DEFAULT = 4;

    // True for the states in which the power stage is actively charging.
    function automatic logic is_charging(state_t s);
        return (s == ST_TC) || (s == ST_CC) || (s == ST_CV);
    endfunction

endpackage

// File: rtl/batcharger_sat_timer.sv
// TW-bit saturating cycle counter with a terminal compare.
// Ports:
//   clk, rst   : clock and synchronous active-high reset.
//   clr        : clear the count. Clear has priority over inc.
//   inc        : increment the count. The count holds at all-ones.
//   limit      : terminal value. A limit of 0 means the counter never hits.
//   hit        : high while count == limit and limit != 0.
module batcharger_sat_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [TW-1:0] limit,
    output logic          hit
);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc && (count != {TW{1'b1}}))
            count <= count + 1'b1;
    end

    assign hit = (limit != '0) && (count == limit);

endmodule

// File: rtl/batcharger_ctrl_fsm.sv
// Charge sequencer for the battery-charger power stage.
// It runs the sequence IDLE -> TC -> CC -> CV -> DONE, with recharge from DONE
// back to CC. It also applies exit debounce, a total-charge timeout, a CV-phase
// timeout and a temperature interlock.
// Ports:
//   clk, rst                   : clock and synchronous active-high reset.
//   en                         : charger enable. Low forces IDLE from any state.
//   tempok                     : battery temperature is within limits.
//   vbat, ibat                 : battery voltage and current ADC codes.
//   vcutoff, vpreset, iend     : TC->CC threshold, recharge threshold and CV
//                                termination current.
//   tmax, tcvmax               : total and CV-phase timeouts in cycles.
//                                A value of 0 disables the timeout.
//   icc_cfg, itc_cfg, vcv_cfg  : requested codes. They are latched in IDLE.
//   cc, tc, cv, pwr_en         : power-stage mode controls (Moore outputs).
//   icc, itc, vcv              : latched codes driven to the power stage.
//   done, fault, state         : status outputs and debug state.
module batcharger_ctrl_fsm
    import batcharger_pkg::*;
#(
    parameter int DEB = DEB_DEFAULT,
    parameter int TW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          tempok,
    input  logic [7:0]    vbat,
    input  logic [7:0]    ibat,
    input  logic [7:0]    vcutoff,
    input  logic [7:0]    vpreset,
    input  logic [7:0]    iend,
    input  logic [TW-1:0] tmax,
    input  logic [TW-1:0] tcvmax,
    input  logic [7:0]    icc_cfg,
    input  logic [7:0]    itc_cfg,
    input  logic [7:0]    vcv_cfg,
    output logic          cc,
    output logic          tc,
    output logic          cv,
    output logic          pwr_en,
    output logic [7:0]    icc,
    output logic [7:0]    itc,
    output logic [7:0]    vcv,
    output logic          done,
    output logic          fault,
    output logic [2:0]    state
);

    localparam logic [3:0] DEB_LAST = 4'(DEB - 1);

    state_t     state_q, nxt;
    logic [3:0] deb_cnt, deb_nxt;
    logic       cond, qual, latch_en;
    logic       chg_q, chg_n;
    logic       tot_hit, cv_hit;

    assign chg_q = is_charging(state_q);
    assign chg_n = is_charging(nxt);

    // Exit condition of the current state. The debounce counter tracks it.
    always_comb begin
        cond = 1'b0;
        case (state_q)
            ST_TC:   cond = (vbat >= vcutoff);
            ST_CC:   cond = (vbat >= vcv);
            ST_CV:   cond = (ibat <= iend);
            ST_DONE: cond = (vbat <  vpreset);
            default: cond = 1'b0;
        endcase
    end

    // Fire on the edge where the count would reach DEB.
    assign qual = cond && (deb_cnt == DEB_LAST);

    always_comb begin
        nxt      = state_q;
        latch_en = 1'b0;
        if (!en)
            nxt = ST_IDLE;
        else if (chg_q && tot_hit)
            nxt = ST_FAULT;
        else if (chg_q && !tempok)
            nxt = ST_IDLE;
        else begin
            case (state_q)
                ST_IDLE: begin
                    if (tempok) begin
                        latch_en = 1'b1;
                        if (vbat < vcutoff)      nxt = ST_TC;
                        else if (vbat < vpreset) nxt = ST_CC;
                        else                     nxt = ST_DONE;
                    end
                end
                ST_TC:    if (qual) nxt = ST_CC;
                ST_CC:    if (qual) nxt = ST_CV;
                ST_CV:    if (cv_hit || qual) nxt = ST_DONE;
                ST_DONE:  if (qual) nxt = ST_CC;
                ST_FAULT: nxt = ST_FAULT;
                default:  nxt = ST_IDLE;
            endcase
        end

        // A state change clears the count, and so does a false condition.
        deb_nxt = '0;
        if ((nxt == state_q) && cond)
            deb_nxt = deb_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            deb_cnt <= '0;
        end else begin
            state_q <= nxt;
            deb_cnt <= deb_nxt;
        end
    end

    // The codes are captured only while leaving IDLE. They hold through DONE
    // and recharge.
    always_ff @(posedge clk) begin
        if (rst) begin
            icc <= '0;
            itc <= '0;
            vcv <= '0;
        end else if (latch_en) begin
            icc <= icc_cfg;
            itc <= itc_cfg;
            vcv <= vcv_cfg;
        end
    end

    // Both timers are driven from the next state. A timer value therefore counts
    // the cycles spent in the phase, including the current cycle. A hit on
    // cycle N then moves the state on edge N.
    batcharger_sat_timer #(.TW(TW)) u_tot_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (!chg_n),
        .inc   (chg_n),
        .limit (tmax),
        .hit   (tot_hit)
    );

    batcharger_sat_timer #(.TW(TW)) u_cv_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (nxt != ST_CV),
        .inc   (nxt == ST_CV),
        .limit (tcvmax),
        .hit   (cv_hit)
    );

    assign tc     = (state_q == ST_TC);
    assign cc     = (state_q == ST_CC);
    assign cv     = (state_q == ST_CV);
    assign pwr_en = chg_q;
    assign done   = (state_q == ST_DONE);
    assign fault  = (state_q == ST_FAULT);
    assign state  = state_q;

endmodule

// File: tb/tb_batcharger_ctrl_fsm.sv
// Self-checking bench for batcharger_ctrl_fsm.
// It runs directed scenarios followed by a randomized run. On every cycle the
// full output set is compared against a cycle-level reference model of the
// charging rules.
module tb_batcharger_ctrl_fsm;

    localparam int DEB = 4;
    localparam int TW  = 16;

    logic          clk = 1'b0;
    logic          rst, en, tempok;
    logic [7:0]    vbat, ibat, vcutoff, vpreset, iend;
    logic [TW-1:0] tmax, tcvmax;
    logic [7:0]    icc_cfg, itc_cfg, vcv_cfg;
    logic          cc, tc, cv, pwr_en, done, fault;
    logic [7:0]    icc, itc, vcv;
    logic [2:0]    state;

    int nvec = 0;
    int nmis = 0;

    // Reference model state.
    // m_st uses the published encoding. m_hold is the run length of the exit
    // condition. m_tot and m_cv are the cycles spent charging and in CV,
    // including the current cycle.
    int         m_st, m_hold, m_tot, m_cv;
    logic [7:0] m_icc, m_itc, m_vcv;

    batcharger_ctrl_fsm #(.DEB(DEB), .TW(TW)) dut (
        .clk(clk), .rst(rst), .en(en), .tempok(tempok),
        .vbat(vbat), .ibat(ibat), .vcutoff(vcutoff), .vpreset(vpreset),
        .iend(iend), .tmax(tmax), .tcvmax(tcvmax),
        .icc_cfg(icc_cfg), .itc_cfg(itc_cfg), .vcv_cfg(vcv_cfg),
        .cc(cc), .tc(tc), .cv(cv), .pwr_en(pwr_en),
        .icc(icc), .itc(itc), .vcv(vcv),
        .done(done), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // One clock edge of the charging rules, in priority order.
    task automatic model_step();
        bit cond, charging;
        int nx;
        if (rst) begin
            m_st = 0; m_hold = 0; m_tot = 0; m_cv = 0;
            m_icc = 8'd0; m_itc = 8'd0; m_vcv = 8'd0;
            return;
        end
        charging = (m_st >= 1) && (m_st <= 3);
        case (m_st)
            1: cond = (vbat >= vcutoff);
            2: cond = (vbat >= m_vcv);
            3: cond = (ibat <= iend);
            4: cond = (vbat <  vpreset);
            default: cond = 1'b0;
        endcase
        nx = m_st;
        if (!en)
            nx = 0;
        else if (charging && tmax != 0 && m_tot == int'(tmax))
            nx = 5;
        else if (charging && !tempok)
            nx = 0;
        else if (m_st == 0) begin
            if (tempok) begin
                m_icc = icc_cfg; m_itc = itc_cfg; m_vcv = vcv_cfg;
                nx = (vbat < vcutoff) ? 1 : (vbat < vpreset) ? 2 : 4;
            end
        end else if (m_st == 3 && tcvmax != 0 && m_cv == int'(tcvmax))
            nx = 4;
        else if (cond && (m_hold + 1 == DEB))
            nx = (m_st == 1) ? 2 : (m_st == 2) ? 3 : (m_st == 3) ? 4 : 2;

        if (nx != m_st)  m_hold = 0;
        else if (cond)   m_hold = m_hold + 1;
        else             m_hold = 0;

        m_tot = (nx >= 1 && nx <= 3) ? sat16(m_tot + 1) : 0;
        m_cv  = (nx == 3) ? ((m_st == 3) ? sat16(m_cv + 1) : 1) : 0;
        m_st  = nx;
    endtask

    function automatic logic [63:0] exp_vec();
        logic [2:0] s;
        s = 3'(m_st);
        return {31'b0, s, m_st == 2, m_st == 1, m_st == 3,
                (m_st >= 1 && m_st <= 3), m_st == 4, m_st == 5,
                m_icc, m_itc, m_vcv};
    endfunction

    function automatic logic [63:0] obs_vec();
        return {31'b0, state, cc, tc, cv, pwr_en, done, fault, icc, itc, vcv};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("cycle", obs_vec(), exp_vec());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_defaults();
        en = 1'b1; tempok = 1'b1;
        vbat = 8'd100; ibat = 8'd100;
        vcutoff = 8'd153; vpreset = 8'd178; iend = 8'd13;
        icc_cfg = 8'd200; itc_cfg = 8'd50; vcv_cfg = 8'd188;
        tmax = '0; tcvmax = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int vb;

    initial begin
        rst = 1'b1;
        set_defaults();
        m_st = 0; m_hold = 0; m_tot = 0; m_cv = 0;
        m_icc = 8'd0; m_itc = 8'd0; m_vcv = 8'd0;

        // Reset state.
        do_reset();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_outs", 64'({cc, tc, cv, pwr_en, done, fault, icc, itc, vcv}), 64'd0);

        // Full charge cycle, then recharge with a changed icc_cfg.
        vbat = 8'd140; tick();
        chk("t1_tc", 64'(tc), 64'd1);
        chk("t1_itc", 64'(itc), 64'd50);
        vbat = 8'd153; ticks(3);
        chk("t1_tc_hold", 64'(tc), 64'd1);
        tick();
        chk("t1_cc", 64'(cc), 64'd1);
        vbat = 8'd188; ticks(3);
        chk("t1_cc_hold", 64'(cc), 64'd1);
        tick();
        chk("t1_cv", 64'(cv), 64'd1);
        ibat = 8'd13; ticks(4);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_modes_off", 64'({cc, tc, cv, pwr_en}), 64'd0);
        icc_cfg = 8'd99; vbat = 8'd170; ticks(3);
        chk("t5_done_hold", 64'(done), 64'd1);
        tick();
        chk("t5_recharge_cc", 64'(cc), 64'd1);
        chk("t5_icc_kept", 64'(icc), 64'd200);

        // A 3-cycle glitch must not qualify, and it must not leave a partial count.
        set_defaults(); do_reset();
        vbat = 8'd140; tick();
        vbat = 8'd150; tick();
        vbat = 8'd160; ticks(3);
        vbat = 8'd150; tick();
        chk("t2_glitch_tc", 64'(tc), 64'd1);
        vbat = 8'd160; ticks(3);
        chk("t2_cleared_tc", 64'(tc), 64'd1);
        tick();
        chk("t2_cc", 64'(cc), 64'd1);

        // Total timeout: fault appears 100 cycles after leaving IDLE.
        set_defaults(); do_reset();
        tmax = 16'd100; vbat = 8'd170; tick();
        chk("t3_cc", 64'(cc), 64'd1);
        ticks(99);
        chk("t3_no_fault_yet", 64'(fault), 64'd0);
        tick();
        chk("t3_fault", 64'(fault), 64'd1);
        chk("t3_fault_state", 64'(state), 64'd5);
        ticks(3);
        chk("t3_fault_sticky", 64'(fault), 64'd1);
        en = 1'b0; tick();
        chk("t3_idle", 64'(state), 64'd0);

        // Temperature interlock in CV, then reset asserted mid-CC.
        set_defaults(); do_reset();
        vbat = 8'd170; tick();
        vbat = 8'd188; ticks(4);
        chk("t4_cv", 64'(cv), 64'd1);
        tempok = 1'b0; tick();
        chk("t4_interlock_idle", 64'(state), 64'd0);
        chk("t4_interlock_cv", 64'(cv), 64'd0);
        tempok = 1'b1; vbat = 8'd170; tick();
        chk("t4_cc_again", 64'(cc), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t4_rst_all0", 64'({state, cc, tc, cv, pwr_en, done, fault, icc, itc, vcv}), 64'd0);

        // Timeout and CC->CV qualification on the same edge: FAULT wins.
        set_defaults(); do_reset();
        tmax = 16'd10; vbat = 8'd170; tick();
        ticks(6);
        vbat = 8'd188; ticks(3);
        chk("t6_still_cc", 64'(state), 64'd2);
        tick();
        chk("t6_fault_wins", 64'(state), 64'd5);
        en = 1'b0; tick();
        chk("t6_fault_to_idle", 64'(state), 64'd0);

        // Randomized run against the model.
        set_defaults(); do_reset();
        vb = 140;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            if (rst) begin
                vcutoff = 8'($urandom_range(140, 160));
                vpreset = 8'($urandom_range(170, 185));
                iend    = 8'($urandom_range(5, 20));
                tmax    = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(40, 400));
                tcvmax  = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(5, 50));
            end
            en     = ($urandom_range(0, 199) != 0);
            tempok = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 99) < 3) vb = $urandom_range(100, 220);
            else vb = vb + $urandom_range(0, 4) - 2;
            if (vb < 0) vb = 0;
            if (vb > 255) vb = 255;
            vbat    = 8'(vb);
            ibat    = 8'($urandom_range(0, 25));
            icc_cfg = 8'($urandom_range(0, 255));
            itc_cfg = 8'($urandom_range(0, 255));
            vcv_cfg = 8'($urandom_range(175, 205));
            tick();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
